// File: rtl/passgate_sel_pkg.sv
// passgate_sel_pkg: state encoding, parameter limits and select decode shared by the select sequencer
package passgate_sel_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DEAD = 2'd1, DRIVE = 2'd2} state_t;
  localparam int DEAD_MIN = 1;
  localparam int DEAD_MAX = 15;
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 255;
  function automatic logic [1:0] onehot(input logic s);
    return s ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/sel_dead_timer.sv
// sel_dead_timer: loadable down-counter whose done flag is high once it has counted out
module sel_dead_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/passgate_sel_ctrl.sv
// passgate_sel_ctrl: break-before-make arbiter driving a two-input pass-gate mux select and driver enables
module passgate_sel_ctrl
  import passgate_sel_pkg::*;
#(
  parameter int DEAD_CYCLES = 2,
  parameter int MIN_HOLD    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic       mux_sel,
  output logic [1:0] drv_en,
  output logic [1:0] grant,
  output logic       busy,
  output logic [7:0] switch_cnt
);
  if (DEAD_CYCLES < DEAD_MIN || DEAD_CYCLES > DEAD_MAX) begin : g_bad_dead
    $error("DEAD_CYCLES out of range");
  end
  if (MIN_HOLD < HOLD_MIN || MIN_HOLD > HOLD_MAX) begin : g_bad_hold
    $error("MIN_HOLD out of range");
  end
  state_t     state, nstate;
  logic       nsel, base_sel, last_gnt, win;
  logic       dead_done, hold_done, dead_load, enter_drive;
  logic [1:0] drv_nxt;
  assign win = &req ? ~last_gnt : req[1];
  assign dead_load = nsel != mux_sel;
  assign enter_drive = nstate == DRIVE && state != DRIVE;
  sel_dead_timer #(.W(8)) u_dead (
    .clk(clk), .rst_n(rst_n), .load(dead_load),
    .load_val(8'(DEAD_CYCLES - 1)), .done(dead_done)
  );
  sel_dead_timer #(.W(8)) u_hold (
    .clk(clk), .rst_n(rst_n), .load(enter_drive),
    .load_val(8'(MIN_HOLD - 1)), .done(hold_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      mux_sel    <= 1'b0;
      drv_en     <= 2'b00;
      busy       <= 1'b0;
      last_gnt   <= 1'b1;
      base_sel   <= 1'b0;
      switch_cnt <= 8'd0;
    end else begin
      state   <= nstate;
      mux_sel <= nsel;
      drv_en  <= drv_nxt;
      busy    <= nstate != IDLE;
      if (dead_load && state != DEAD) base_sel <= mux_sel;
      if (enter_drive) last_gnt <= nsel;
      if (enter_drive && state == DEAD && mux_sel != base_sel && switch_cnt != 8'hff)
        switch_cnt <= switch_cnt + 8'd1;
    end
  // every select toggle lands in DEAD; the drivers stay off until the timer counts out
  always_comb begin
    nstate = state;
    nsel   = mux_sel;
    case (state)
      IDLE:
        if (req != 2'b00) begin
          nstate = win == mux_sel ? DRIVE : DEAD;
          nsel   = win;
        end
      DEAD:
        if (dead_done) begin
          if (req[mux_sel]) nstate = DRIVE;
          else if (req[~mux_sel]) nsel = ~mux_sel;
          else nstate = IDLE;
        end
      DRIVE:
        if (hold_done) begin
          if (req[~mux_sel]) begin
            nstate = DEAD;
            nsel   = ~mux_sel;
          end else if (!req[mux_sel]) nstate = IDLE;
        end
      default: nstate = IDLE;
    endcase
  end
  always_comb drv_nxt = nstate == DRIVE ? onehot(nsel) : 2'b00;
  assign grant = drv_en;
endmodule

// File: tb/tb_passgate_sel_ctrl.sv
// tb_passgate_sel_ctrl: randomized and directed checks against a cycle-count model of the sequencer
module tb_passgate_sel_ctrl;
  localparam int D = 2;
  localparam int H = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       mux_sel;
  logic [1:0] drv_en, grant;
  logic       busy;
  logic [7:0] switch_cnt;
  int vecs = 0, errs = 0;
  int m_sel, m_drive, m_dead, m_held, m_last, m_base, m_cnt;
  int prev_drv = 0, prev_sel = 0;

  passgate_sel_ctrl #(.DEAD_CYCLES(D), .MIN_HOLD(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mux_sel(mux_sel),
    .drv_en(drv_en), .grant(grant), .busy(busy), .switch_cnt(switch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_drive = 0; m_dead = 0; m_held = 0; m_last = 1; m_base = 0; m_cnt = 0;
  endtask

  // one clock edge of the sequencer, described as cycle counts rather than states
  task automatic model_step();
    int rs, ro, w;
    rs = m_sel ? int'(req[1]) : int'(req[0]);
    ro = m_sel ? int'(req[0]) : int'(req[1]);
    if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) begin
        if (rs != 0) begin
          m_drive = 1; m_held = 0; m_last = m_sel;
          if (m_sel != m_base && m_cnt < 255) m_cnt++;
        end else if (ro != 0) begin
          m_sel = 1 - m_sel; m_dead = D;
        end
      end
    end else if (m_drive != 0) begin
      m_held++;
      if (m_held >= H) begin
        if (ro != 0) begin
          m_drive = 0; m_base = m_sel; m_sel = 1 - m_sel; m_dead = D;
        end else if (rs == 0) m_drive = 0;
      end
    end else if (req != 2'b00) begin
      w = req == 2'b11 ? 1 - m_last : int'(req[1]);
      if (w == m_sel) begin
        m_drive = 1; m_held = 0; m_last = w;
      end else begin
        m_base = m_sel; m_sel = w; m_dead = D;
      end
    end
  endtask

  task automatic tick(input logic [1:0] r);
    req = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    check("drv_en", drv_en, m_drive != 0 ? (m_sel != 0 ? 2 : 1) : 0);
    check("grant", grant, m_drive != 0 ? (m_sel != 0 ? 2 : 1) : 0);
    check("mux_sel", mux_sel, m_sel);
    check("busy", busy, (m_drive != 0 || m_dead > 0) ? 1 : 0);
    check("switch_cnt", switch_cnt, m_cnt);
    check("drv_overlap", drv_en == 2'b11 ? 1 : 0, 0);
    if (prev_drv != 0 && drv_en != 2'b00) check("sel_stable", mux_sel, prev_sel);
    prev_drv = drv_en;
    prev_sel = mux_sel;
  end

  logic [1:0] tie_exp [13] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                               2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_drv", drv_en, 0);
    check("rst_cnt", switch_cnt, 0);
    tick(2'b01);
    check("first_drv", drv_en, 1);
    check("first_sel", mux_sel, 0);
    check("first_cnt", switch_cnt, 0);
    do_reset();
    tick(2'b10);
    check("sw_sel_t1", mux_sel, 1);
    check("sw_drv_t1", drv_en, 0);
    tick(2'b10);
    check("sw_drv_t2", drv_en, 0);
    tick(2'b10);
    check("sw_drv_t3", drv_en, 2);
    check("sw_cnt", switch_cnt, 1);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      tick(2'b11);
      check("tie_grant", grant, tie_exp[i]);
    end
    check("tie_cnt", switch_cnt, 2);
    do_reset();
    tick(2'b01);
    tick(2'b01);
    tick(2'b11);
    tick(2'b11);
    check("hold_keep", drv_en, 1);
    tick(2'b11);
    check("hold_break", drv_en, 0);
    check("hold_sel", mux_sel, 1);
    do_reset();
    tick(2'b10);
    #2 rst_n = 1'b0;
    #1 check("arst_dead_sel", mux_sel, 0);
    check("arst_dead_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2'b01);
    check("arst_drive_pre", drv_en, 1);
    #2 rst_n = 1'b0;
    #1 check("arst_drive_drv", drv_en, 0);
    check("arst_drive_grant", grant, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2'b01);
    check("resume_drv", drv_en, 1);
    for (int i = 0; i < 3000; ) begin
      int len;
      logic [1:0] r;
      len = $urandom_range(1, 8);
      r = 2'($urandom_range(0, 3));
      for (int k = 0; k < len; k++) tick(r);
      i += len;
    end
    do_reset();
    for (int i = 0; i < 1850; i++) tick(2'b11);
    check("sat_cnt", switch_cnt, 255);
    @(negedge clk);
    #1 $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
